// File: rtl/vga_timing_pkg.sv
// Shared raster constants for 640x480@60 and sync-window helpers used by the
// timing generator and by downstream pixel stages.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync windows are half-open: [START, END)
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    function automatic bit in_window(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives position/sync/strobes and
// consumes the pixel clock enable.
interface vga_timing_gen_if #(
    parameter int FRAME_W = 8
);
    logic               ce;
    logic               hsync;
    logic               vsync;
    logic [9:0]         x_px;
    logic [9:0]         y_px;
    logic               activevideo;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame;

    modport master (
        input  ce,
        output hsync, vsync, x_px, y_px, activevideo, line_start, frame_start, frame
    );

    modport slave (
        output ce,
        input  hsync, vsync, x_px, y_px, activevideo, line_start, frame_start, frame
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decodes of the value the
// counter will hold after this clock, so the parent can register them in step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL_DEF,
    parameter int SYNC_START = H_SYNC_START_DEF,
    parameter int SYNC_END   = H_SYNC_END_DEF,
    parameter int VISIBLE    = H_VISIBLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_next,
    output logic             vis_next
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;
    logic             w_wrap;

    always_comb begin
        w_wrap = inc && (r_count == CNT_W'(TOTAL - 1));
        w_next = r_count;
        if (w_wrap) begin
            w_next = '0;
        end else if (inc) begin
            w_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count     = r_count;
    assign wrap      = w_wrap;
    assign sync_next = in_window(int'(w_next), SYNC_START, SYNC_END);
    assign vis_next  = int'(w_next) < VISIBLE;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: full-raster coordinates, registered syncs/strobes
// aligned with the coordinates they describe, and a wrapping frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int FRAME_W   = 8
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: raster total exceeds 10-bit coordinate range");
    end

    logic [CNT_W-1:0]   w_x;
    logic [CNT_W-1:0]   w_y;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_h_sync_next;
    logic               w_v_sync_next;
    logic               w_h_vis_next;
    logic               w_v_vis_next;
    logic               w_v_inc;

    logic               r_hsync;
    logic               r_vsync;
    logic               r_active;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame;

    assign w_v_inc = vif.ce & w_h_wrap;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .SYNC_START(H_VISIBLE + H_FRONT),
        .SYNC_END(H_VISIBLE + H_FRONT + H_SYNC), .VISIBLE(H_VISIBLE)
    ) u_h (
        .clk(clk), .reset(reset), .inc(vif.ce),
        .count(w_x), .wrap(w_h_wrap), .sync_next(w_h_sync_next), .vis_next(w_h_vis_next)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .SYNC_START(V_VISIBLE + V_FRONT),
        .SYNC_END(V_VISIBLE + V_FRONT + V_SYNC), .VISIBLE(V_VISIBLE)
    ) u_v (
        .clk(clk), .reset(reset), .inc(w_v_inc),
        .count(w_y), .wrap(w_v_wrap), .sync_next(w_v_sync_next), .vis_next(w_v_vis_next)
    );

    // With ce high, the next position is (x=0) exactly on an h wrap and
    // (0,0) exactly on a v wrap; the v wrap is also the moment the
    // first-frame-seen condition becomes true, so frame_start follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_active      <= 1'b1;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame       <= '0;
        end else if (vif.ce) begin
            r_hsync       <= w_h_sync_next ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_v_sync_next ? VSYNC_POL : ~VSYNC_POL;
            r_active      <= w_h_vis_next & w_v_vis_next;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    assign vif.x_px        = w_x;
    assign vif.y_px        = w_y;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.activevideo = r_active;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;
    assign vif.frame       = r_frame;

endmodule
